alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Instruction-side driver for the integer ALU: accepts one decoded-register-read instruction per handshake, maps MIPS opcode/funct to the 5-bit ALU operation code, drives the ALU operand/control inputs from registers, waits the required cycles, captures the result/flag, and returns a writeback/branch/exception record. Sits between the register-read stage and writeback. It drives the ALU's control inputs and reads back its outputs.

## Interface
- MD_WAIT, 8: extra cycles ALU inputs are held stable before capture for MULT/DIV (multicycle path); legal 0..15.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid / in_ready  in / out  1  instruction handshake; transfer when both high.
- in_instr  in  32  instruction word.
- in_rs, in_rt  in  32  register values for rs, rt.
- alu_op1, alu_op2  out  32  ALU operands (registered).
- alu_smt  out  5  shift amount (registered).
- alu_aluop  out  5  ALU operation code (registered).
- alu_r1  in  32  ALU result; alu_uf  in  1  ALU flag.
- out_valid / out_ready  out / in  1  result handshake.
- out_res  out  32  result; out_dst  out  5  destination register; out_wr_en  out  1  write enable.
- out_branch  out  1  branch taken; out_exc  out  2  00 none, 01 overflow, 10 divide-by-zero, 11 illegal.

## Operation
- Op codes: PASS 00000, ADD 00001, SUB 00010, AND 00011, OR 00100, XOR 00110, SLL 00111, SRL 01000, LT 01001, EQ 01011, NE 01100, LUI 01111, MULT 10000, DIV 10001.
- R-type (opcode 0), funct: add 20h/addu 21h→ADD; sub 22h/subu 23h→SUB; and 24h; or 25h; xor 26h; sll 00h, srl 02h (op1=rt, smt=shamt); slt 2Ah/sltu 2Bh→LT; mult 18h; div 1Ah. op1=rs, op2=rt, dst=rd.
- I-type: addi 08h/addiu 09h→ADD, slti 0Ah/sltiu 0Bh→LT (sign-extended imm); andi 0Ch, ori 0Dh, xori 0Eh (zero-extended imm); lui 0Fh→LUI (op2=zero-extended imm); dst=rt. beq 04h→EQ, bne 05h→NE, op2=rt, wr_en=0, dst=0.
- Signed compares (slt, slti): both operands issued with bit 31 inverted; unsigned variants issued unmodified.
- Result: LT → {31'b0, alu_uf}; EQ/NE → out_branch=alu_uf, out_res=0; MULT/DIV → low 32 bits of alu_r1 to rd; else alu_r1.
- Overflow (add, addi): exc=01 when alu_uf=1. Overflow (sub): computed locally, (op1[31]^op2[31])&(op1[31]^alu_r1[31]); alu_uf ignored. addu/addiu/subu never trap.
- DIV with in_rt==0: not issued, exc=10, res=0. Unlisted opcode/funct: not issued, exc=11, res=0.
- Any exc≠00 or dst==0 forces out_wr_en=0.

## Timing
- FSM: IDLE → ISSUE → (WAIT for MULT/DIV) → RESP → IDLE; illegal/div-by-zero IDLE → RESP.
- in_ready=1 only in IDLE. Accept at edge T; ALU inputs valid from T+1 (ISSUE).
- Single-cycle ops: result captured at end of ISSUE; out_valid high from T+2.
- MULT/DIV: WAIT counts MD_WAIT cycles with ALU inputs frozen; out_valid from T+2+MD_WAIT.
- Illegal/div0: out_valid from T+1; ALU inputs remain PASS/zero.
- RESP holds all out_* stable until out_ready; transfer edge returns to IDLE, in_ready high next cycle. Minimum 3 cycles per instruction.
- Outside ISSUE/WAIT: alu_aluop=PASS, operands and smt unchanged.
- Reset values: in_ready=0 during reset, 1 after release; out_valid=0, out_res=0, out_dst=0, out_wr_en=0, out_branch=0, out_exc=00, alu_op1=alu_op2=0, alu_smt=0, alu_aluop=PASS, state IDLE, wait counter 0.
- Reset asserted mid-operation: immediate return to reset values; in-flight instruction discarded, no response.

## Structure
- Shared package alu_pkg: ALU op code constants, exception codes, opcode/funct constants, FSM state enum.
- One combinational sub-module alu_decode: instruction → op code, operand selects, immediate extension, dst, class flags (trap, signed-compare, multicycle, branch, illegal). FSM, counter and capture registers in the top module.

## Test plan
- add r3,r1,r2 with rs=5, rt=7, ALU returns 12 → out_valid at T+2, res=12, dst=3, wr_en=1, exc=00.
- add with rs=7FFFFFFFh, rt=1, ALU r1=80000000h, uf=1 → exc=01, wr_en=0; addu same values → exc=00, wr_en=1.
- slt with rs=FFFFFFFFh, rt=1 → ALU sees op1=7FFFFFFFh, op2=80000001h; ALU uf=1 → res=1.
- div with rt=0 → out_valid at T+1, exc=10, alu_aluop stays PASS; div 100/7 with MD_WAIT=8 → out_valid at T+10, ALU inputs stable 9 cycles.
- beq with rs=rt=9, ALU uf=1 → out_branch=1, wr_en=0; out_ready low 5 cycles → outputs stable, in_ready low throughout.
- rst_n asserted during WAIT → all outputs to reset values asynchronously; after release, next instruction completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue controller.
// ALU op codes, MIPS opcode/funct values, exception codes, FSM states.
package alu_pkg;

  localparam logic [4:0] OP_PASS = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_SLL  = 5'b00111;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_LT   = 5'b01001;
  localparam logic [4:0] OP_EQ   = 5'b01011;
  localparam logic [4:0] OP_NE   = 5'b01100;
  localparam logic [4:0] OP_LUI  = 5'b01111;
  localparam logic [4:0] OP_MULT = 5'b10000;
  localparam logic [4:0] OP_DIV  = 5'b10001;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_DIV0 = 2'b10;
  localparam logic [1:0] EXC_ILL  = 2'b11;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [4:0]  aluop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  smt;
    logic [4:0]  dst;
    logic        wr;
    logic        trap_add;
    logic        trap_sub;
    logic        lt;
    logic        br;
    logic        mc;
    logic        ill;
    logic        div0;
  } dec_t;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Instruction decode: opcode/funct to ALU op, operands and class flags.
// Signed compares are issued with bit 31 of both operands inverted.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output dec_t        dec
);

  logic [5:0]  opc;
  logic [5:0]  fn;
  logic [31:0] sext;
  logic [31:0] zext;
  logic        sgn;
  logic        unused_rs;

  assign opc       = instr[31:26];
  assign fn        = instr[5:0];
  assign sext      = {{16{instr[15]}}, instr[15:0]};
  assign zext      = {16'h0, instr[15:0]};
  assign unused_rs = ^instr[25:21];

  always_comb begin
    dec     = '0;
    dec.op1 = rs;
    dec.op2 = rt;
    dec.dst = instr[15:11];
    dec.wr  = 1'b1;
    sgn     = 1'b0;
    unique case (opc)
      OPC_RTYPE: begin
        unique case (fn)
          FN_ADD:  begin dec.aluop = OP_ADD; dec.trap_add = 1'b1; end
          FN_ADDU: dec.aluop = OP_ADD;
          FN_SUB:  begin dec.aluop = OP_SUB; dec.trap_sub = 1'b1; end
          FN_SUBU: dec.aluop = OP_SUB;
          FN_AND:  dec.aluop = OP_AND;
          FN_OR:   dec.aluop = OP_OR;
          FN_XOR:  dec.aluop = OP_XOR;
          FN_SLL: begin
            dec.aluop = OP_SLL;
            dec.op1   = rt;
            dec.smt   = instr[10:6];
          end
          FN_SRL: begin
            dec.aluop = OP_SRL;
            dec.op1   = rt;
            dec.smt   = instr[10:6];
          end
          FN_SLT:  begin dec.aluop = OP_LT; dec.lt = 1'b1; sgn = 1'b1; end
          FN_SLTU: begin dec.aluop = OP_LT; dec.lt = 1'b1; end
          FN_MULT: begin dec.aluop = OP_MULT; dec.mc = 1'b1; end
          FN_DIV: begin
            dec.aluop = OP_DIV;
            dec.mc    = 1'b1;
            dec.div0  = (rt == 32'h0);
          end
          default: dec.ill = 1'b1;
        endcase
      end
      OPC_ADDI: begin
        dec.aluop    = OP_ADD;
        dec.op2      = sext;
        dec.dst      = instr[20:16];
        dec.trap_add = 1'b1;
      end
      OPC_ADDIU: begin
        dec.aluop = OP_ADD;
        dec.op2   = sext;
        dec.dst   = instr[20:16];
      end
      OPC_SLTI: begin
        dec.aluop = OP_LT;
        dec.op2   = sext;
        dec.dst   = instr[20:16];
        dec.lt    = 1'b1;
        sgn       = 1'b1;
      end
      OPC_SLTIU: begin
        dec.aluop = OP_LT;
        dec.op2   = sext;
        dec.dst   = instr[20:16];
        dec.lt    = 1'b1;
      end
      OPC_ANDI: begin
        dec.aluop = OP_AND;
        dec.op2   = zext;
        dec.dst   = instr[20:16];
      end
      OPC_ORI: begin
        dec.aluop = OP_OR;
        dec.op2   = zext;
        dec.dst   = instr[20:16];
      end
      OPC_XORI: begin
        dec.aluop = OP_XOR;
        dec.op2   = zext;
        dec.dst   = instr[20:16];
      end
      OPC_LUI: begin
        dec.aluop = OP_LUI;
        dec.op2   = zext;
        dec.dst   = instr[20:16];
      end
      OPC_BEQ: begin
        dec.aluop = OP_EQ;
        dec.dst   = 5'd0;
        dec.wr    = 1'b0;
        dec.br    = 1'b1;
      end
      OPC_BNE: begin
        dec.aluop = OP_NE;
        dec.dst   = 5'd0;
        dec.wr    = 1'b0;
        dec.br    = 1'b1;
      end
      default: dec.ill = 1'b1;
    endcase
    if (sgn) begin
      dec.op1[31] = ~dec.op1[31];
      dec.op2[31] = ~dec.op2[31];
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accept, issue to ALU, wait, capture, respond.
// ALU inputs are frozen through ISSUE/WAIT so MULT/DIV see a stable path.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int MD_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [4:0]  alu_smt,
  output logic [4:0]  alu_aluop,
  input  logic [31:0] alu_r1,
  input  logic        alu_uf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [4:0]  out_dst,
  output logic        out_wr_en,
  output logic        out_branch,
  output logic [1:0]  out_exc
);

  localparam logic [3:0] CNT_LAST = 4'(MD_WAIT - 1);

  dec_t       dec;
  state_t     state;
  logic [3:0] cnt;
  logic [4:0] dst_q;
  logic       wr_q;
  logic       tadd_q;
  logic       tsub_q;
  logic       lt_q;
  logic       br_q;
  logic       mc_q;

  logic        sub_ovf;
  logic        ovf;
  logic        last;
  logic [31:0] res_c;

  alu_decode u_dec (
    .instr (in_instr),
    .rs    (in_rs),
    .rt    (in_rt),
    .dec   (dec)
  );

  // sub overflow judged from the issued operands, not the ALU flag
  assign sub_ovf = (alu_op1[31] ^ alu_op2[31])
                 & (alu_op1[31] ^ alu_r1[31]);
  assign ovf     = (tadd_q & alu_uf) | (tsub_q & sub_ovf);
  assign res_c   = lt_q ? {31'h0, alu_uf}
                 : br_q ? 32'h0
                 : alu_r1;
  assign last    = (state == S_ISSUE && (MD_WAIT == 0 || !mc_q))
                || (state == S_WAIT && cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      in_ready   <= 1'b0;
      alu_op1    <= 32'h0;
      alu_op2    <= 32'h0;
      alu_smt    <= 5'd0;
      alu_aluop  <= OP_PASS;
      out_valid  <= 1'b0;
      out_res    <= 32'h0;
      out_dst    <= 5'd0;
      out_wr_en  <= 1'b0;
      out_branch <= 1'b0;
      out_exc    <= EXC_NONE;
      dst_q      <= 5'd0;
      wr_q       <= 1'b0;
      tadd_q     <= 1'b0;
      tsub_q     <= 1'b0;
      lt_q       <= 1'b0;
      br_q       <= 1'b0;
      mc_q       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            dst_q    <= dec.dst;
            wr_q     <= dec.wr;
            tadd_q   <= dec.trap_add;
            tsub_q   <= dec.trap_sub;
            lt_q     <= dec.lt;
            br_q     <= dec.br;
            mc_q     <= dec.mc;
            if (dec.ill || dec.div0) begin
              state      <= S_RESP;
              out_valid  <= 1'b1;
              out_res    <= 32'h0;
              out_dst    <= dec.dst;
              out_wr_en  <= 1'b0;
              out_branch <= 1'b0;
              out_exc    <= dec.ill ? EXC_ILL : EXC_DIV0;
            end else begin
              state     <= S_ISSUE;
              alu_op1   <= dec.op1;
              alu_op2   <= dec.op2;
              alu_smt   <= dec.smt;
              alu_aluop <= dec.aluop;
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          if (last) begin
            state      <= S_RESP;
            cnt        <= 4'd0;
            alu_aluop  <= OP_PASS;
            out_valid  <= 1'b1;
            out_res    <= res_c;
            out_dst    <= dst_q;
            out_exc    <= ovf ? EXC_OVF : EXC_NONE;
            out_wr_en  <= wr_q & ~ovf & (dst_q != 5'd0);
            out_branch <= br_q & alu_uf;
          end else if (state == S_ISSUE) begin
            state <= S_WAIT;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed table, reset corner, random vs model.
// The bench plays the ALU, returning fixed r1/uf per instruction.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int MD = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [4:0]  alu_smt;
  logic [4:0]  alu_aluop;
  logic [31:0] alu_r1;
  logic        alu_uf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_dst;
  logic        out_wr_en;
  logic        out_branch;
  logic [1:0]  out_exc;

  alu_issue_ctrl #(.MD_WAIT(MD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_smt    (alu_smt),
    .alu_aluop  (alu_aluop),
    .alu_r1     (alu_r1),
    .alu_uf     (alu_uf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_dst    (out_dst),
    .out_wr_en  (out_wr_en),
    .out_branch (out_branch),
    .out_exc    (out_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] r1;
    logic        uf;
    logic [4:0]  aluop;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  smt;
    logic [31:0] res;
    logic [4:0]  dst;
    logic        wr;
    logic        br;
    logic [1:0]  exc;
    int          lat;
    int          hold;
  } vec_t;

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(int s, int t, int d,
                                        int sh, int f);
    return {6'h0, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(f)};
  endfunction

  function automatic logic [31:0] itype(int o, int s, int t, int imm);
    return {6'(o), 5'(s), 5'(t), 16'(imm)};
  endfunction

  function automatic vec_t mk(
    logic [31:0] instr, logic [31:0] rs, logic [31:0] rt,
    logic [31:0] r1, int uf, logic [4:0] aluop,
    logic [31:0] op1, logic [31:0] op2, int smt,
    logic [31:0] res, int dst, int wr, int br, int exc,
    int lat, int hold);
    vec_t v;
    v.instr = instr; v.rs = rs; v.rt = rt; v.r1 = r1;
    v.uf = 1'(uf); v.aluop = aluop; v.op1 = op1; v.op2 = op2;
    v.smt = 5'(smt); v.res = res; v.dst = 5'(dst);
    v.wr = 1'(wr); v.br = 1'(br); v.exc = 2'(exc);
    v.lat = lat; v.hold = hold;
    return v;
  endfunction

  // Reference: what an instruction should produce, from the ISA rules
  function automatic vec_t model(logic [31:0] instr, logic [31:0] rs,
                                 logic [31:0] rt, logic [31:0] r1,
                                 logic uf);
    vec_t v;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] se;
    logic [31:0] ze;
    logic [31:0] flip;
    int kind;
    bit legal;
    bit md;
    bit ovf;
    opc = instr[31:26];
    fn = instr[5:0];
    se = 32'($signed(instr[15:0]));
    ze = 32'(instr[15:0]);
    flip = 32'h8000_0000;
    v = mk(instr, rs, rt, r1, 0, OP_PASS, rs, rt, 0, 0, 0, 1, 0, 0, 0, 0);
    v.uf = uf;
    v.dst = instr[15:11];
    kind = 0;
    legal = 1;
    md = 0;
    if (opc == 6'h00) begin
      case (fn)
        6'h20: begin v.aluop = OP_ADD; kind = 1; end
        6'h21: v.aluop = OP_ADD;
        6'h22: begin v.aluop = OP_SUB; kind = 2; end
        6'h23: v.aluop = OP_SUB;
        6'h24: v.aluop = OP_AND;
        6'h25: v.aluop = OP_OR;
        6'h26: v.aluop = OP_XOR;
        6'h00, 6'h02: begin
          v.aluop = (fn == 6'h00) ? OP_SLL : OP_SRL;
          v.op1 = rt;
          v.smt = instr[10:6];
        end
        6'h2A: begin
          v.aluop = OP_LT; kind = 3;
          v.op1 = rs + flip; v.op2 = rt + flip;
        end
        6'h2B: begin v.aluop = OP_LT; kind = 3; end
        6'h18: begin v.aluop = OP_MULT; md = 1; end
        6'h1A: begin v.aluop = OP_DIV; md = 1; end
        default: legal = 0;
      endcase
    end else begin
      v.dst = instr[20:16];
      case (opc)
        6'h08: begin v.aluop = OP_ADD; v.op2 = se; kind = 1; end
        6'h09: begin v.aluop = OP_ADD; v.op2 = se; end
        6'h0A: begin
          v.aluop = OP_LT; kind = 3;
          v.op1 = rs + flip; v.op2 = se + flip;
        end
        6'h0B: begin v.aluop = OP_LT; v.op2 = se; kind = 3; end
        6'h0C: begin v.aluop = OP_AND; v.op2 = ze; end
        6'h0D: begin v.aluop = OP_OR; v.op2 = ze; end
        6'h0E: begin v.aluop = OP_XOR; v.op2 = ze; end
        6'h0F: begin v.aluop = OP_LUI; v.op2 = ze; end
        6'h04, 6'h05: begin
          v.aluop = (opc == 6'h04) ? OP_EQ : OP_NE;
          kind = 4; v.dst = 0; v.wr = 0;
        end
        default: legal = 0;
      endcase
    end
    if (!legal) begin
      v.aluop = OP_PASS; v.exc = 3; v.res = 0; v.wr = 0; v.lat = 1;
    end else if (opc == 6'h00 && fn == 6'h1A && rt == 0) begin
      v.aluop = OP_PASS; v.exc = 2; v.res = 0; v.wr = 0; v.lat = 1;
    end else begin
      ovf = (kind == 1 && uf)
         || (kind == 2 && rs[31] != rt[31] && r1[31] != rs[31]);
      v.exc = ovf ? 2'd1 : 2'd0;
      v.res = (kind == 3) ? {31'h0, uf} : (kind == 4) ? 32'h0 : r1;
      v.br = (kind == 4) && uf;
      v.wr = v.wr && !ovf && (v.dst != 0);
      v.lat = md ? 2 + MD : 2;
    end
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int n;
    bit got;
    bit issued;
    issued = (v.exc < 2);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = v.instr;
    in_rs = v.rs;
    in_rt = v.rt;
    alu_r1 = v.r1;
    alu_uf = v.uf;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid) got = 1;
      else if (issued) begin
        chk({tag, ".aluop"}, 32'(alu_aluop), 32'(v.aluop));
        chk({tag, ".op1"}, alu_op1, v.op1);
        chk({tag, ".op2"}, alu_op2, v.op2);
        if (v.aluop == OP_SLL || v.aluop == OP_SRL)
          chk({tag, ".smt"}, 32'(alu_smt), 32'(v.smt));
      end
    end
    chk({tag, ".latency"}, 32'(n), 32'(v.lat));
    chk({tag, ".aluop_idle"}, 32'(alu_aluop), 32'(OP_PASS));
    chk({tag, ".res"}, out_res, v.res);
    chk({tag, ".wr"}, 32'(out_wr_en), 32'(v.wr));
    chk({tag, ".br"}, 32'(out_branch), 32'(v.br));
    chk({tag, ".exc"}, 32'(out_exc), 32'(v.exc));
    if (issued) chk({tag, ".dst"}, 32'(out_dst), 32'(v.dst));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_res"}, out_res, v.res);
      chk({tag, ".hold_br"}, 32'(out_branch), 32'(v.br));
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".done_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  vec_t tbl[$];
  int   fns[13] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26,
                    'h00, 'h02, 'h2A, 'h2B, 'h18, 'h1A};
  int   iops[10] = '{'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E,
                     'h0F, 'h04, 'h05};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int k;
    logic [31:0] ins;
    logic [31:0] rt;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'h0;
    in_rs = 32'h0;
    in_rt = 32'h0;
    alu_r1 = 32'h0;
    alu_uf = 1'b0;
    out_ready = 1'b0;
    #3;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.aluop", 32'(alu_aluop), 32'(OP_PASS));
    chk("rst.op1", alu_op1, 32'h0);
    chk("rst.out_exc", 32'(out_exc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    tbl.push_back(mk(rtype(1, 2, 3, 0, 'h20), 5, 7, 12, 0, OP_ADD,
                     5, 7, 0, 12, 3, 1, 0, 0, 2, 0));
    tbl.push_back(mk(rtype(1, 2, 3, 0, 'h20), 32'h7FFF_FFFF, 1,
                     32'h8000_0000, 1, OP_ADD, 32'h7FFF_FFFF, 1, 0,
                     32'h8000_0000, 3, 0, 0, 1, 2, 0));
    tbl.push_back(mk(rtype(1, 2, 3, 0, 'h21), 32'h7FFF_FFFF, 1,
                     32'h8000_0000, 1, OP_ADD, 32'h7FFF_FFFF, 1, 0,
                     32'h8000_0000, 3, 1, 0, 0, 2, 1));
    tbl.push_back(mk(rtype(1, 2, 3, 0, 'h2A), 32'hFFFF_FFFF, 1, 0, 1,
                     OP_LT, 32'h7FFF_FFFF, 32'h8000_0001, 0,
                     1, 3, 1, 0, 0, 2, 0));
    tbl.push_back(mk(rtype(4, 5, 6, 0, 'h1A), 100, 0, 32'h55, 0,
                     OP_PASS, 0, 0, 0, 0, 6, 0, 0, 2, 1, 0));
    tbl.push_back(mk(rtype(1, 2, 6, 0, 'h1A), 100, 7, 14, 0, OP_DIV,
                     100, 7, 0, 14, 6, 1, 0, 0, 2 + MD, 0));
    tbl.push_back(mk(itype('h04, 1, 2, 'h10), 9, 9, 32'h55, 1, OP_EQ,
                     9, 9, 0, 0, 0, 0, 1, 0, 2, 5));
    tbl.push_back(mk(rtype(1, 2, 3, 0, 'h22), 32'h8000_0000, 1,
                     32'h7FFF_FFFF, 0, OP_SUB, 32'h8000_0000, 1, 0,
                     32'h7FFF_FFFF, 3, 0, 0, 1, 2, 0));
    tbl.push_back(mk(rtype(1, 2, 3, 0, 'h23), 32'h8000_0000, 1,
                     32'h7FFF_FFFF, 0, OP_SUB, 32'h8000_0000, 1, 0,
                     32'h7FFF_FFFF, 3, 1, 0, 0, 2, 0));
    tbl.push_back(mk(rtype(1, 2, 3, 0, 'h22), 5, 3, 2, 1, OP_SUB,
                     5, 3, 0, 2, 3, 1, 0, 0, 2, 0));
    tbl.push_back(mk(itype('h0F, 0, 4, 'h1234), 0, 0, 32'h1234_0000, 0,
                     OP_LUI, 0, 32'h1234, 0, 32'h1234_0000, 4, 1, 0, 0,
                     2, 0));
    tbl.push_back(mk(32'hFC00_0000, 1, 2, 32'h77, 0, OP_PASS, 0, 0, 0,
                     0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(mk(rtype(3, 2, 5, 4, 'h00), 32'h55, 1, 16, 0, OP_SLL,
                     1, 1, 4, 16, 5, 1, 0, 0, 2, 0));
    tbl.push_back(mk(itype('h08, 1, 0, 'hFFFF), 1, 9, 0, 0, OP_ADD,
                     1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(itype('h0A, 1, 2, 'h8000), 3, 9, 0, 0, OP_LT,
                     32'h8000_0003, 32'h7FFF_8000, 0, 0, 2, 1, 0, 0,
                     2, 0));
    tbl.push_back(mk(itype('h0C, 1, 2, 'h8000), 32'hF0F0, 9, 32'h8000, 0,
                     OP_AND, 32'hF0F0, 32'h8000, 0, 32'h8000, 2, 1, 0,
                     0, 2, 0));
    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // reset in the middle of a DIV wait window
    in_valid = 1'b1;
    in_instr = rtype(1, 2, 6, 0, 'h1A);
    in_rs = 100;
    in_rt = 7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid.aluop", 32'(alu_aluop), 32'(OP_DIV));
    #2 rst_n = 1'b0;
    #1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.aluop_rst", 32'(alu_aluop), 32'(OP_PASS));
    chk("mid.op1", alu_op1, 32'h0);
    chk("mid.op2", alu_op2, 32'h0);
    chk("mid.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid.no_resp", 32'(out_valid), 32'd0);
    run(tbl[0], "after_rst");

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 23);
      if (k < 13)
        ins = rtype($urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 31),
                    fns[k]);
      else if (k < 23)
        ins = itype(iops[k - 13], $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 65535));
      else
        ins = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      v = model(ins, $urandom, rt, $urandom, 1'($urandom_range(0, 1)));
      v.hold = $urandom_range(0, 2);
      run(v, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
